// File: rtl/tuple_drainer_if.sv
// rtl/tuple_drainer_if.sv - anonymizer read port, drain control and tuple output stream bundle
interface tuple_drainer_if #(
    parameter int ADDR_WIDTH      = 8,
    parameter int Q_ID_WIDTH      = 32,
    parameter int Q_ID_MASK_WIDTH = 6,
    parameter int S_ATTR_WIDTH    = 512
);
    // drain control
    logic [ADDR_WIDTH:0]          window_size;
    logic                         all_finished;
    logic                         busy;
    logic                         done;

    // anonymizer read port
    logic [ADDR_WIDTH-1:0]        read_address;
    logic [Q_ID_WIDTH-1:0]        q_id_in;
    logic [Q_ID_MASK_WIDTH-1:0]   q_id_mask_in;
    logic [S_ATTR_WIDTH-1:0]      s_attr_in;

    // tuple output stream
    logic                         out_valid;
    logic                         out_ready;
    logic [Q_ID_WIDTH-1:0]        out_q_id;
    logic [Q_ID_MASK_WIDTH-1:0]   out_q_id_mask;
    logic [S_ATTR_WIDTH-1:0]      out_s_attr;
    logic [ADDR_WIDTH-1:0]        out_index;
    logic                         out_last;

    modport master (
        input  window_size, all_finished, q_id_in, q_id_mask_in, s_attr_in, out_ready,
        output busy, done, read_address, out_valid, out_q_id, out_q_id_mask,
               out_s_attr, out_index, out_last
    );

    modport slave (
        output window_size, all_finished, q_id_in, q_id_mask_in, s_attr_in, out_ready,
        input  busy, done, read_address, out_valid, out_q_id, out_q_id_mask,
               out_s_attr, out_index, out_last
    );
endinterface

// File: rtl/tuple_drainer.sv
// rtl/tuple_drainer.sv - drains anonymized tuples from a read port onto a valid/ready stream
module tuple_drainer #(
    parameter int ADDR_WIDTH      = 8,
    parameter int Q_ID_WIDTH      = 32,
    parameter int Q_ID_MASK_WIDTH = 6,
    parameter int S_ATTR_WIDTH    = 512
) (
    input logic            clk,
    input logic            rst,
    tuple_drainer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_HOLD    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0]        CNT_ONE = 1;
    localparam logic [Q_ID_MASK_WIDTH-1:0] Q_ID_W  = Q_ID_MASK_WIDTH'(Q_ID_WIDTH);

    state_t                       state;
    state_t                       state_nxt;
    logic                         af_q;
    logic                         armed;
    logic [ADDR_WIDTH:0]          count;
    logic [ADDR_WIDTH-1:0]        index;
    logic [Q_ID_WIDTH-1:0]        q_id_r;
    logic [Q_ID_MASK_WIDTH-1:0]   q_id_mask_r;
    logic [S_ATTR_WIDTH-1:0]      s_attr_r;
    logic [ADDR_WIDTH-1:0]        out_index_r;
    logic [Q_ID_WIDTH-1:0]        keep_bits;
    logic                         start_edge;
    logic                         at_last;

    // armed only once all_finished has been seen low since reset, so a level held through reset never starts a drain
    assign start_edge = bus.all_finished & ~af_q & armed;
    // widened compare so a full 2^ADDR_WIDTH window ends on the top address without wrapping
    assign at_last    = ({1'b0, index} == (count - CNT_ONE));

    // generalization mask: keep the top q_id_mask_in bits, zero the rest
    always_comb begin
        keep_bits = '1;
        if (bus.q_id_mask_in < Q_ID_W) begin
            keep_bits = ~({Q_ID_WIDTH{1'b1}} >> bus.q_id_mask_in);
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    state_nxt = (bus.window_size == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_HOLD;
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = at_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                if (!bus.all_finished) begin
                    state_nxt = S_IDLE;
                end
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // state-derived outputs
    always_comb begin
        bus.busy      = (state == S_ISSUE) || (state == S_CAPTURE) || (state == S_HOLD);
        bus.done      = (state == S_DONE);
        bus.out_valid = (state == S_HOLD);
        bus.out_last  = (state == S_HOLD) && at_last;
    end

    // edge detect, window latch, index walk and tuple capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            af_q        <= 1'b0;
            armed       <= 1'b0;
            count       <= '0;
            index       <= '0;
            q_id_r      <= '0;
            q_id_mask_r <= '0;
            s_attr_r    <= '0;
            out_index_r <= '0;
        end else begin
            af_q <= bus.all_finished;
            if (!bus.all_finished) begin
                armed <= 1'b1;
            end
            if (state == S_IDLE && start_edge) begin
                count <= bus.window_size;
                index <= '0;
            end
            if (state == S_CAPTURE) begin
                q_id_r      <= bus.q_id_in & keep_bits;
                q_id_mask_r <= bus.q_id_mask_in;
                s_attr_r    <= bus.s_attr_in;
                out_index_r <= index;
            end
            if (state == S_HOLD && bus.out_ready && !at_last) begin
                index <= index + 1'b1;
            end
        end
    end

    assign bus.read_address  = index;
    assign bus.out_q_id      = q_id_r;
    assign bus.out_q_id_mask = q_id_mask_r;
    assign bus.out_s_attr    = s_attr_r;
    assign bus.out_index     = out_index_r;

endmodule
